seg7_scan_driver: RTL and testbench

- Time-multiplexed driver for a bank of DIGITS common-anode/cathode 7-segment digits sharing one segment bus.
- Latches a packed hex value, decimal points and blank mask on a load strobe into a shadow register, so a digit never shows a torn update.
- Scans one digit at a time at a programmable rate, with dead-time between digits and optional leading-zero suppression.
- Sits between any value-producing logic (counters, calculators) and the board display pins.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_scan_driver.sv | 103 ++++++++++
 tb/tb_seg7_scan_driver.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment encoding and sizing helpers for the scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_DARK = 7'b1111111;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}; entry 0 sits in the LSBs.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
    };

    function automatic int slot_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern (g..a).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_LUT[i_nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner with shadowed display data,
// per-slot dead-time and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int DEAD           = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SW             = slot_width(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lzs,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     an,
    output logic [SW-1:0]         slot_o
);

    localparam int              PW      = $clog2(SCAN_DIV);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]      SEG_XOR = (SEG_ACTIVE_LOW != 0) ? '0 : '1;
    localparam logic            DP_XOR  = (SEG_ACTIVE_LOW == 0);

    logic [PW-1:0]         r_presc;
    logic [SW-1:0]         r_slot;
    logic [4*DIGITS-1:0]   r_value;
    logic [DIGITS-1:0]     r_dp;
    logic [DIGITS-1:0]     r_blank;
    logic                  r_lzs;
    logic [6:0]            r_seg;
    logic                  r_seg_dp;
    logic [DIGITS-1:0]     r_an;

    logic                  w_wrap;
    logic [PW-1:0]         w_presc_nxt;
    logic [SW-1:0]         w_slot_nxt;
    logic [4*DIGITS-1:0]   w_val_sh;
    logic [DIGITS-1:0]     w_dp_sh;
    logic [DIGITS-1:0]     w_an_on;
    logic [3:0]            w_nib;
    logic [6:0]            w_pat;
    logic                  w_supp;
    logic                  w_dark;

    assign w_wrap      = (r_presc == PW'(SCAN_DIV - 1));
    assign w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);
    assign w_slot_nxt  = !w_wrap ? r_slot :
                         (r_slot == SW'(DIGITS - 1)) ? '0 : r_slot + SW'(1);

    // Outputs are registered from the next scan position, so an/seg line up with slot_o.
    assign w_val_sh = r_value >> {w_slot_nxt, 2'b00};
    assign w_dp_sh  = r_dp >> w_slot_nxt;
    assign w_nib    = w_val_sh[3:0];
    assign w_an_on  = {{(DIGITS-1){1'b0}}, 1'b1} << w_slot_nxt;

    // Suppressed when this digit and everything above it is zero with no dp lit.
    assign w_supp = r_lzs && (w_slot_nxt != '0) && (w_val_sh == '0) && (w_dp_sh == '0);
    assign w_dark = (int'(w_presc_nxt) < DEAD) || r_blank[w_slot_nxt] || w_supp;

    hex_to_seg7 u_dec (
        .i_nib (w_nib),
        .o_seg (w_pat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc  <= '0;
            r_slot   <= '0;
            r_value  <= '0;
            r_dp     <= '0;
            r_blank  <= '1;
            r_lzs    <= 1'b0;
            r_an     <= AN_OFF;
            r_seg    <= SEG_DARK ^ SEG_XOR;
            r_seg_dp <= 1'b1 ^ DP_XOR;
        end else begin
            r_presc  <= w_presc_nxt;
            r_slot   <= w_slot_nxt;
            if (load) begin
                r_value <= value;
                r_dp    <= dp;
                r_blank <= blank;
                r_lzs   <= lzs;
            end
            r_an     <= w_dark ? AN_OFF : (AN_OFF ^ w_an_on);
            r_seg    <= (w_dark ? SEG_DARK : w_pat) ^ SEG_XOR;
            r_seg_dp <= (w_dark ? 1'b1 : ~w_dp_sh[0]) ^ DP_XOR;
        end
    end

    assign seg    = r_seg;
    assign seg_dp = r_seg_dp;
    assign an     = r_an;
    assign slot_o = r_slot;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: DIGITS=4, SCAN_DIV=4, DEAD=1, active-low pins.
module tb_seg7_scan_driver;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] slot;
    } exp_t;

    localparam logic [6:0] DK = 7'b1111111;
    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] PA = 7'b0001000;
    localparam logic [6:0] PF = 7'b0001110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic        lzs = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic [1:0]  slot_o;

    seg7_scan_driver #(
        .DIGITS(4), .SCAN_DIV(4), .DEAD(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp),
        .blank(blank), .lzs(lzs), .seg(seg), .seg_dp(seg_dp), .an(an), .slot_o(slot_o)
    );

    always #5 clk = ~clk;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    bit         running = 1'b1;
    logic [6:0] cur_seg[4];
    logic [6:0] pend_seg[4];
    logic [3:0] cur_dp = '0;
    logic [3:0] pend_dp = '0;
    int         p = 0;
    int         s = 0;

    task automatic clear_tables();
        for (int i = 0; i < 4; i++) cur_seg[i] = DK;
        cur_dp = '0;
    endtask

    // Expected digit table applies from the edge after the load edge.
    task automatic set_phase(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                             input logic l, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
        value = v; dp = d; blank = b; lzs = l;
        pend_seg[0] = s0; pend_seg[1] = s1; pend_seg[2] = s2; pend_seg[3] = s3;
        pend_dp = d;
    endtask

    task automatic step(input logic ld);
        exp_t e;
        load = ld;
        @(posedge clk);
        #1;
        if (rst) begin
            p = 0; s = 0;
        end else begin
            p = (p == 3) ? 0 : p + 1;
            if (p == 0) s = (s + 1) % 4;
        end
        e.slot = 2'(s);
        if (rst || p < 1 || cur_seg[s] == DK) begin
            e.an = 4'hF; e.seg = DK; e.dp = 1'b1;
        end else begin
            e.an = ~(4'b0001 << s); e.seg = cur_seg[s]; e.dp = ~cur_dp[s];
        end
        q.push_back(e);
        if (ld && !rst) begin
            cur_seg = pend_seg;
            cur_dp  = pend_dp;
        end
        load = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({an, seg, seg_dp, slot_o} !== e)
                $display("FAIL scan t=%0t got an=%b seg=%b dp=%b slot=%0d need an=%b seg=%b dp=%b slot=%0d",
                         $time, an, seg, seg_dp, slot_o, e.an, e.seg, e.dp, e.slot);
            if ({an, seg, seg_dp, slot_o} !== e) errors++;
        end else if (running) begin
            checks++;
            errors++;
            $display("FAIL underflow t=%0t got no expected entry need one per cycle", $time);
        end
    end

    initial begin
        exp_t e;
        clear_tables();
        for (int i = 0; i < 4; i++) pend_seg[i] = DK;

        repeat (3) step(1'b0);
        rst = 1'b0;
        repeat (20) step(1'b0);

        set_phase(16'h12AF, 4'b0000, 4'b0000, 1'b0, PF, PA, P2, P1);
        step(1'b1); repeat (18) step(1'b0);

        set_phase(16'h0050, 4'b0000, 4'b0000, 1'b1, P0, P5, DK, DK);
        step(1'b1); repeat (17) step(1'b0);

        set_phase(16'h0050, 4'b0100, 4'b0000, 1'b1, P0, P5, P0, DK);
        step(1'b1); repeat (17) step(1'b0);

        set_phase(16'h0000, 4'b0000, 4'b0000, 1'b1, P0, DK, DK, DK);
        step(1'b1); repeat (17) step(1'b0);

        set_phase(16'h0000, 4'b0000, 4'b0001, 1'b1, DK, DK, DK, DK);
        step(1'b1); repeat (17) step(1'b0);

        set_phase(16'h1111, 4'b0000, 4'b0000, 1'b0, P1, P1, P1, P1);
        step(1'b1); repeat (9) step(1'b0);
        while (p != 3) step(1'b0);
        set_phase(16'h2222, 4'b0000, 4'b0000, 1'b0, P2, P2, P2, P2);
        step(1'b1); repeat (13) step(1'b0);

        // Asynchronous reset between edges while a digit is lit.
        while (p != 2) step(1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        p = 0; s = 0;
        clear_tables();
        e.an = 4'hF; e.seg = DK; e.dp = 1'b1; e.slot = 2'd0;
        q.push_back(e);
        repeat (2) step(1'b0);
        rst = 1'b0;
        repeat (10) step(1'b0);

        @(negedge clk);
        #1;
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
